// File: rtl/baud_pkg.sv
// Shared baud-rate constants: the rate table and the rounded clock-divisor function
// used by the divisor ROM and by the reset value of the active divisor.
package baud_pkg;

  localparam int BAUD_NUM_RATES = 12;
  localparam logic [3:0] BAUD_DEFAULT_CODE = 4'd0;
  localparam logic [3:0] BAUD_FASTEST_CODE = 4'd11;

  localparam int unsigned BAUD_RATE_TABLE [BAUD_NUM_RATES] = '{
    300, 1200, 2400, 4800, 9600, 19200,
    38400, 57600, 115200, 230400, 460800, 921600
  };

  // Codes outside the table fall back to the default (300 baud) entry.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input logic [3:0] code);
    int unsigned rate;
    if (code < 4'(BAUD_NUM_RATES)) rate = BAUD_RATE_TABLE[code];
    else                           rate = BAUD_RATE_TABLE[BAUD_DEFAULT_CODE];
    return (clk_hz + rate / 2) / rate;
  endfunction

endpackage

// File: rtl/baud_divisor_rom.sv
// Combinational baud code -> clock divisor lookup; every entry is an elaboration-time constant.
module baud_divisor_rom
  import baud_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int          CNT_W  = 19
) (
  input  logic [3:0]       code,
  output logic [CNT_W-1:0] k
);

  logic [CNT_W-1:0] k_table [16];

  for (genvar i = 0; i < 16; i++) begin : g_entry
    assign k_table[i] = CNT_W'(baud_div(CLK_HZ, 4'(i)));
  end

  assign k = k_table[code];

endmodule

// File: rtl/baud_gen.sv
// Baud-rate tick generator: a fractional accumulator adds OVERSAMPLE per enabled clock and
// wraps at the divisor, giving evenly spread oversample ticks and an exact bit period.
module baud_gen
  import baud_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int          OVERSAMPLE = 16,
  parameter int          CNT_W      = 19
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       baud,
  input  logic             enable,
  input  logic             sync_clr,
  output logic             tick,
  output logic             os_tick,
  output logic [CNT_W-1:0] div,
  output logic             bad_sel
);

  localparam int               OS_W      = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W:0]   OS_STEP   = (CNT_W + 1)'(OVERSAMPLE);
  localparam logic [CNT_W-1:0] OS_INC    = CNT_W'(OVERSAMPLE);
  localparam logic [CNT_W-1:0] DIV_RESET = CNT_W'(baud_div(CLK_HZ, BAUD_DEFAULT_CODE));
  localparam logic [3:0]       BAD_FIRST = 4'(BAUD_NUM_RATES);

  if (OVERSAMPLE < 1 || OVERSAMPLE > int'(baud_div(CLK_HZ, BAUD_FASTEST_CODE))) begin : g_bad_os
    $error("baud_gen: OVERSAMPLE must lie in 1..divisor of the fastest rate");
  end
  if (longint'(baud_div(CLK_HZ, BAUD_DEFAULT_CODE)) >= (longint'(1) << CNT_W)) begin : g_bad_w
    $error("baud_gen: CNT_W too narrow for the slowest-rate divisor");
  end

  logic [3:0]       sel_q;
  logic [CNT_W-1:0] acc;
  logic [OS_W-1:0]  os_idx;
  logic [CNT_W-1:0] k_new;
  logic             reload;
  logic [CNT_W:0]   sum;
  logic             wrap;
  logic [CNT_W-1:0] acc_wrap;
  logic             os_last;

  baud_divisor_rom #(
    .CLK_HZ (CLK_HZ),
    .CNT_W  (CNT_W)
  ) u_rom (
    .code (baud),
    .k    (k_new)
  );

  assign reload   = (baud != sel_q);
  assign sum      = {1'b0, acc} + OS_STEP;
  assign wrap     = (sum >= {1'b0, div});
  // acc + OVERSAMPLE - div is below div, so modulo-2^CNT_W arithmetic is exact here.
  assign acc_wrap = acc + OS_INC - div;
  assign os_last  = (os_idx == OS_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q   <= BAUD_DEFAULT_CODE;
      div     <= DIV_RESET;
      acc     <= '0;
      os_idx  <= '0;
      tick    <= 1'b0;
      os_tick <= 1'b0;
      bad_sel <= 1'b0;
    end else if (reload) begin
      sel_q   <= baud;
      div     <= k_new;
      acc     <= '0;
      os_idx  <= '0;
      tick    <= 1'b0;
      os_tick <= 1'b0;
      bad_sel <= (baud >= BAD_FIRST);
    end else if (sync_clr) begin
      acc     <= '0;
      os_idx  <= '0;
      tick    <= 1'b0;
      os_tick <= 1'b0;
    end else if (!enable) begin
      tick    <= 1'b0;
      os_tick <= 1'b0;
    end else if (wrap) begin
      acc     <= acc_wrap;
      os_tick <= 1'b1;
      tick    <= os_last;
      os_idx  <= os_last ? '0 : os_idx + OS_W'(1);
    end else begin
      acc     <= sum[CNT_W-1:0];
      tick    <= 1'b0;
      os_tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_baud_gen.sv
// Directed bench for baud_gen: divisor selection, oversample spacing, bit period,
// restart behaviour (reload, sync_clr, enable hold, async reset) and a 50 MHz instance.
module tb_baud_gen;

  localparam int CLK_PERIOD = 10;

  logic        clk      = 1'b0;
  logic        reset_n  = 1'b1;
  logic [3:0]  baud     = 4'd0;
  logic        enable   = 1'b0;
  logic        sync_clr = 1'b0;
  logic        tick, os_tick, bad_sel;
  logic [18:0] div;

  logic [3:0]  baud_b     = 4'd8;
  logic        enable_b   = 1'b1;
  logic        sync_clr_b = 1'b0;
  logic        tick_b, os_tick_b, bad_sel_b;
  logic [18:0] div_b;

  int cyc   = 0;
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  baud_gen #(.CLK_HZ(100_000_000), .OVERSAMPLE(16), .CNT_W(19)) dut (
    .clk(clk), .reset_n(reset_n), .baud(baud), .enable(enable), .sync_clr(sync_clr),
    .tick(tick), .os_tick(os_tick), .div(div), .bad_sel(bad_sel)
  );

  baud_gen #(.CLK_HZ(50_000_000), .OVERSAMPLE(16), .CNT_W(19)) dut_b (
    .clk(clk), .reset_n(reset_n), .baud(baud_b), .enable(enable_b), .sync_clr(sync_clr_b),
    .tick(tick_b), .os_tick(os_tick_b), .div(div_b), .bad_sel(bad_sel_b)
  );

  // ---------------- clock / reset ----------------
  always #(CLK_PERIOD / 2) clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #(CLK_PERIOD * 100_000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) edge_step();
  endtask

  task automatic set_baud(input logic [3:0] b, input logic [31:0] exp_div);
    baud = b;
    edge_step();
    check("reload_tick", tick, 0);
    check("reload_os_tick", os_tick, 0);
    check("reload_div", div, exp_div);
  endtask

  task automatic wait_tick(input int max, output int n);
    n = 0;
    do begin
      edge_step();
      n++;
    end while (!tick && n < max);
    if (!tick) n = -1;
  endtask

  // One full bit from a restart: first os_tick, spacing, count, tick position.
  task automatic run_bit(input int k, input int os);
    int lo, hi, last, n_os, first_os, tick_at, n_tick, bad_gap, lonely;
    lo = k / os;
    hi = (k + os - 1) / os;
    last = 0; n_os = 0; first_os = 0; tick_at = 0; n_tick = 0; bad_gap = 0; lonely = 0;
    for (int e = 1; e <= k; e++) begin
      edge_step();
      if (os_tick) begin
        if (n_os == 0) first_os = e;
        else if (e - last < lo || e - last > hi) bad_gap++;
        last = e;
        n_os++;
      end
      if (tick) begin
        tick_at = e;
        n_tick++;
        if (!os_tick) lonely++;
      end
    end
    check("first_os_edge", first_os, hi);
    check("os_tick_count", n_os, os);
    check("os_gap_out_of_range", bad_gap, 0);
    check("tick_count", n_tick, 1);
    check("tick_edge", tick_at, k);
    check("tick_without_os", lonely, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, base, pulses, found;

    // Reset values
    #1 reset_n = 1'b0;
    #2;
    check("rst_tick", tick, 0);
    check("rst_os_tick", os_tick, 0);
    check("rst_div", div, 333_333);
    check("rst_bad_sel", bad_sel, 0);
    #20 reset_n = 1'b1;
    edge_step();
    check("idle_div", div, 333_333);

    // 115200 baud: div 868, two consecutive bits
    enable = 1'b1;
    set_baud(4'd8, 868);
    check("bad_sel_code8", bad_sel, 0);
    run_bit(868, 16);
    run_bit(868, 16);

    // 921600 baud: div 109, then 100 bits of zero drift through the scoreboard
    set_baud(4'd11, 109);
    run_bit(109, 16);
    base = cyc;
    for (int i = 1; i <= 100; i++) exp_q.push_back(32'(base + 109 * i));
    for (int e = 0; e < 100 * 109 + 5; e++) begin
      edge_step();
      if (tick) begin
        if (exp_q.size() == 0) check("drift_extra_tick", cyc, 0);
        else check("drift_tick_cycle", cyc, exp_q.pop_front());
      end
    end
    check("drift_missing_ticks", exp_q.size(), 0);

    // Baud change mid-bit: 8 -> 4
    set_baud(4'd8, 868);
    idle(400);
    set_baud(4'd4, 10_417);
    run_bit(10_417, 16);

    // sync_clr on the edge the tick is due
    set_baud(4'd8, 868);
    idle(867);
    sync_clr = 1'b1;
    edge_step();
    sync_clr = 1'b0;
    check("sync_tick_dropped", tick, 0);
    check("sync_os_tick_dropped", os_tick, 0);
    run_bit(868, 16);

    // enable low for 50 cycles mid-bit stretches the bit by exactly 50
    idle(300);
    enable = 1'b0;
    pulses = 0;
    for (int e = 0; e < 50; e++) begin
      edge_step();
      if (tick || os_tick) pulses++;
    end
    check("hold_pulses", pulses, 0);
    enable = 1'b1;
    wait_tick(2000, n);
    check("hold_tick_remaining", n, 568);

    // Out-of-table code
    set_baud(4'd13, 333_333);
    check("bad_sel_code13", bad_sel, 1);

    // Async reset mid-bit while an os_tick is showing
    set_baud(4'd8, 868);
    found = 0;
    for (int e = 0; e < 100 && found == 0; e++) begin
      edge_step();
      if (os_tick) found = 1;
    end
    check("pre_reset_os_tick_seen", found, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_os_tick", os_tick, 0);
    check("async_rst_tick", tick, 0);
    check("async_rst_div", div, 333_333);
    check("async_rst_bad_sel", bad_sel, 0);
    #2 reset_n = 1'b1;
    edge_step();
    check("post_rst_div", div, 868);
    check("post_rst_os_tick", os_tick, 0);
    run_bit(868, 16);

    // 50 MHz instance
    check("clk50_div", div_b, 434);
    check("clk50_bad_sel", bad_sel_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/baud_gen.md
# baud_gen

Parameterised baud-rate tick generator for the UART transmit and receive paths. It maps a 4-bit baud-select code to a clock divisor computed from `CLK_HZ`. From that divisor it produces two pulses: a one-cycle bit tick exactly every divisor clocks, and an oversample tick evenly distributed `OVERSAMPLE` times per bit. It restarts cleanly on a baud change or on a receiver resync request.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency in Hz; sets all divisors.
- `OVERSAMPLE`, 16, oversample ticks per bit; range 1..min divisor (109 at 100 MHz).
- `CNT_W`, 19, divisor and accumulator width; must hold the 300-baud divisor.
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `baud`  in  4  rate select: 0..11 = 300, 1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600; 12..15 = 300.
- `enable`  in  1  run when high; hold phase when low.
- `sync_clr`  in  1  synchronous phase restart (RX start-bit edge).
- `tick`  out  1  one-cycle bit-rate pulse.
- `os_tick`  out  1  one-cycle oversample pulse.
- `div`  out  CNT_W  currently active divisor k.
- `bad_sel`  out  1  high while the latched code is 12..15.

## Operation
- Divisor: k = (CLK_HZ + rate/2) / rate, rounded to nearest. At 100 MHz this gives 333_333, 83_333, 41_667, 20_833, 10_417, 5_208, 2_604, 1_736, 868, 434, 217, 109.
- State registers:
  - `sel_q` (latched code)
  - `div` = k(sel_q)
  - `acc` (CNT_W bits, always < k)
  - `os_idx` (max(1, clog2(OVERSAMPLE)) bits)
- Rising edge, priority order:
  1. **Reload.** If `baud != sel_q`: `sel_q <= baud`, `div <= k(baud)`, `acc <= 0`, `os_idx <= 0`, both ticks 0.
  2. **Resync.** Else if `sync_clr`: `acc <= 0`, `os_idx <= 0`, both ticks 0.
  3. **Hold.** Else if `!enable`: `acc` and `os_idx` hold; both ticks 0.
  4. **Step.** Else compute s = acc + OVERSAMPLE (CNT_W+1 bits).
     - If s >= div: `acc <= s - div`, `os_tick <= 1`, `os_idx` increments and wraps at OVERSAMPLE-1, `tick <= (os_idx == OVERSAMPLE-1)`.
     - Otherwise: `acc <= s`, both ticks 0.
- Consequences:
  - Exactly OVERSAMPLE `os_tick`s per div enabled cycles.
  - os_tick spacing is floor(div/OVERSAMPLE) or ceil(div/OVERSAMPLE), never both adjacent out of order.
  - `tick` always coincides with an `os_tick`.
  - Bit period is exactly div cycles; no accumulated error.
- OVERSAMPLE = 1: `os_tick == tick` every cycle.
- `bad_sel` is a registered decode of `sel_q >= 12`.

## Timing
- Reset values: `sel_q` = 0, `div` = 333_333 at default CLK_HZ, `acc` = 0, `os_idx` = 0, `tick` = 0, `os_tick` = 0, `bad_sel` = 0.
- Pulses are registered. After a restart (reset, reload or `sync_clr`) with `enable` held high:
  - first `os_tick` is visible after enabled edge ceil(div/OVERSAMPLE);
  - first `tick` is visible after enabled edge div.
- A baud change takes effect on the next edge. The divisor changes on that edge and the restart cycle emits no pulse.
- Simultaneous events: a pending tick coinciding with reload or `sync_clr` is dropped. Reload wins over `sync_clr`.
- Disabled cycles stretch the phase but do not reset it.
- Reset mid-bit aborts immediately and asynchronously; ticks drop the same cycle.
- `baud` must be synchronous to `clk`; no internal synchroniser.

## Structure
- Package `baud_pkg`:
  - rate table (12 entries, Hz);
  - function `baud_div(clk_hz, code)` returning the rounded divisor, with the default entry for codes 12..15;
  - constant `BAUD_DEFAULT_CODE` = 0.
- Sub-module `baud_divisor_rom` (combinational, parameter CLK_HZ): code -> k. It replaces the fixed-clock decode table.
- Top module: reload detect, accumulator, `os_idx` counter, output registers.
- Elaboration check: OVERSAMPLE <= k(921600) and the 300-baud k fits in CNT_W.

## Test plan
- Reset, then `baud` = 8, `enable` = 1 (default params) -> `div` = 868; `os_tick` first at edge 55; 16 `os_tick`s per 868 cycles, gaps of 54 or 55; `tick` every 868 cycles, aligned with the 16th `os_tick`.
- `baud` = 11, OVERSAMPLE = 16 -> `div` = 109; `os_tick` gaps of 6 or 7; `tick` every 109 cycles over 100 bits with zero drift.
- Change `baud` 8 -> 4 mid-bit -> no pulse on the change cycle; `div` = 10_417; first `tick` 10_417 edges later.
- `sync_clr` on the same edge a `tick` is due -> tick suppressed; next `tick` 868 edges later. `enable` low for 50 cycles mid-bit -> that bit's `tick` delayed by exactly 50.
- `baud` = 13 -> `div` = 333_333, `bad_sel` = 1. CLK_HZ = 50_000_000, `baud` = 8 -> `div` = 434.
- `reset_n` asserted mid-bit between edges -> all outputs to reset values immediately; after release, counting restarts from `acc` = 0.
